// File: rtl/rf_regfile_pkg.sv
// Shared widths, register indices and types for the MIPS register file.
// reset_val() gives the power-on contents of each architectural register.
package RF_my_pkg;

  localparam int WD     = 32;
  localparam int SEL    = 5;
  localparam int NREG   = 32;
  localparam int GP_IDX = 28;
  localparam int SP_IDX = 29;
  localparam int CNT_W  = $clog2(NREG) + 1;

  typedef logic [WD-1:0] word_t;
  typedef word_t reg_array_t [NREG];

  function automatic word_t reset_val(input int idx, input word_t gp, input word_t sp);
    if (idx == GP_IDX) return gp;
    if (idx == SP_IDX) return sp;
    return '0;
  endfunction

endpackage

// File: rtl/rf_regfile_if.sv
// Register-file access bundle: write request, two read addresses, read data and operand latches.
// master drives requests (control/decoder side), slave is the register file.
interface rf_regfile_if;
  import RF_my_pkg::*;

  logic           reg_write;
  logic [WD-1:0]  wr_onehot;
  logic [WD-1:0]  wd;
  logic [SEL-1:0] ra1;
  logic [SEL-1:0] ra2;
  logic [WD-1:0]  rd1;
  logic [WD-1:0]  rd2;
  logic [WD-1:0]  a_q;
  logic [WD-1:0]  b_q;
  logic           onehot_err;

  modport master (
    output reg_write, wr_onehot, wd, ra1, ra2,
    input  rd1, rd2, a_q, b_q, onehot_err
  );

  modport slave (
    input  reg_write, wr_onehot, wd, ra1, ra2,
    output rd1, rd2, a_q, b_q, onehot_err
  );

endinterface

// File: rtl/rf_reg_cell.sv
// One architectural register: load-enabled flop with a per-instance reset value.
// Latency: q updates on the rising edge where ld=1; no backpressure.
module rf_reg_cell #(
  parameter int            WD      = 32,
  parameter logic [WD-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld,
  input  logic [WD-1:0] d,
  output logic [WD-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rf_regfile.sv
// 32x32 MIPS register file: one-hot write select, two combinational read ports, A/B operand latches.
// Reads are zero-latency, a_q/b_q one cycle after ra; no backpressure, multi-hot writes dropped and flagged.
module rf_regfile
  import RF_my_pkg::*;
#(
  parameter word_t GP_INIT = 32'h1000_8000,
  parameter word_t SP_INIT = 32'h7FFF_EFFC
) (
  input  logic         clk,
  input  logic         rst_n,
  rf_regfile_if.slave  bus
);

  reg_array_t       regs;
  logic [CNT_W-1:0] sel_cnt;
  logic             legal_wr;
  logic             multi_wr;
  logic             a_hit;
  logic             b_hit;
  word_t            a_nxt;
  word_t            b_nxt;
  logic             err;

  // Bit 0 never counts: the decoder's $0 encoding is either 0 or a harmless bit 0.
  always_comb begin
    sel_cnt = '0;
    for (int i = 1; i < NREG; i++) begin
      sel_cnt = sel_cnt + CNT_W'(bus.wr_onehot[i]);
    end
  end

  assign legal_wr = bus.reg_write && (sel_cnt == CNT_W'(1));
  assign multi_wr = bus.reg_write && (sel_cnt > CNT_W'(1));

  assign regs[0] = '0;

  for (genvar g = 1; g < NREG; g++) begin : g_cell
    rf_reg_cell #(
      .WD      (WD),
      .RST_VAL (reset_val(g, GP_INIT, SP_INIT))
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (legal_wr && bus.wr_onehot[g]),
      .d     (bus.wd),
      .q     (regs[g])
    );
  end

  assign bus.rd1 = regs[bus.ra1];
  assign bus.rd2 = regs[bus.ra2];

  // Write-through bypass so the latch sees the value the register holds after this edge.
  assign a_hit = legal_wr && (bus.ra1 != '0) && bus.wr_onehot[bus.ra1];
  assign b_hit = legal_wr && (bus.ra2 != '0) && bus.wr_onehot[bus.ra2];
  assign a_nxt = a_hit ? bus.wd : bus.rd1;
  assign b_nxt = b_hit ? bus.wd : bus.rd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.a_q <= '0;
      bus.b_q <= '0;
      err     <= 1'b0;
    end else begin
      bus.a_q <= a_nxt;
      bus.b_q <= b_nxt;
      if (multi_wr) begin
        err <= 1'b1;
      end
    end
  end

  assign bus.onehot_err = err;

endmodule

// File: tb/tb_rf_regfile.sv
// Bench for rf_regfile: directed vector table, corner sequences, randomized run against an array model.
module tb_rf_regfile;

  localparam logic [31:0] GP = 32'h1000_8000;
  localparam logic [31:0] SP = 32'h7FFF_EFFC;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rf_regfile_if bus();

  rf_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        rw;
    logic [31:0] oh;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        e_err;
  } vec_t;

  vec_t        tbl[13];
  logic [31:0] mem[32];
  logic        err_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rw, input logic [31:0] oh, input logic [31:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    bus.reg_write = rw;
    bus.wr_onehot = oh;
    bus.wd        = wd;
    bus.ra1       = ra1;
    bus.ra2       = ra2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[28] = GP;
    mem[29] = SP;
    err_m   = 1'b0;
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    logic [31:0] oh;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        rw;
    int          n;
    int          idx;
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 5'd0);

    //            rw   oh            wd            ra1 ra2  rd1           rd2           a_q           b_q           err
    tbl[0]  = '{1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 28,  9, GP,           32'h0,        GP,           32'hDEAD_BEEF, 1'b0};
    tbl[1]  = '{1'b0, 32'h0,         32'h0,          9, 29, 32'hDEAD_BEEF, SP,          32'hDEAD_BEEF, SP,           1'b0};
    tbl[2]  = '{1'b1, 32'h0000_0001, 32'hFFFF_FFFF,  0,  0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
    tbl[3]  = '{1'b0, 32'h0,         32'h0,          0,  9, 32'h0,        32'hDEAD_BEEF, 32'h0,       32'hDEAD_BEEF, 1'b0};
    tbl[4]  = '{1'b1, 32'h0000_0020, 32'h1111_1111,  1,  2, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
    tbl[5]  = '{1'b1, 32'h0000_0020, 32'h2222_2222,  5,  5, 32'h1111_1111, 32'h1111_1111, 32'h2222_2222, 32'h2222_2222, 1'b0};
    tbl[6]  = '{1'b1, 32'h0,         32'h3333_3333,  5,  6, 32'h2222_2222, 32'h0,       32'h2222_2222, 32'h0,       1'b0};
    tbl[7]  = '{1'b1, 32'h0000_0040, 32'h4444_4444,  6,  7, 32'h0,        32'h0,        32'h4444_4444, 32'h0,       1'b0};
    tbl[8]  = '{1'b1, 32'h0000_0060, 32'hAAAA_AAAA,  5,  6, 32'h2222_2222, 32'h4444_4444, 32'h2222_2222, 32'h4444_4444, 1'b1};
    tbl[9]  = '{1'b0, 32'h0,         32'h0,          5,  6, 32'h2222_2222, 32'h4444_4444, 32'h2222_2222, 32'h4444_4444, 1'b1};
    tbl[10] = '{1'b1, 32'h8000_0000, 32'h0BAD_F00D, 31, 30, 32'h0,        32'h0,        32'h0BAD_F00D, 32'h0,       1'b1};
    tbl[11] = '{1'b1, 32'h0000_0003, 32'h1234_5678,  1,  0, 32'h0,        32'h0,        32'h1234_5678, 32'h0,       1'b1};
    tbl[12] = '{1'b0, 32'h0,         32'h0,          1, 31, 32'h1234_5678, 32'h0BAD_F00D, 32'h1234_5678, 32'h0BAD_F00D, 1'b1};

    // Reset asserted mid-cycle, then every address read while held.
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 32; i++) begin
      bus.ra1 = 5'(i);
      #1;
      check($sformatf("reset_rd1[%0d]", i), bus.rd1, mem[i]);
    end
    check("reset_a_q", bus.a_q, 32'h0);
    check("reset_b_q", bus.b_q, 32'h0);
    check("reset_err", {31'h0, bus.onehot_err}, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[k]) begin
      drive(tbl[k].rw, tbl[k].oh, tbl[k].wd, tbl[k].ra1, tbl[k].ra2);
      #1;
      check($sformatf("vec%0d_rd1", k), bus.rd1, tbl[k].e_rd1);
      check($sformatf("vec%0d_rd2", k), bus.rd2, tbl[k].e_rd2);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_a_q", k), bus.a_q, tbl[k].e_a);
      check($sformatf("vec%0d_b_q", k), bus.b_q, tbl[k].e_b);
      check($sformatf("vec%0d_err", k), {31'h0, bus.onehot_err}, {31'h0, tbl[k].e_err});
    end

    // Multi-hot and X selects with reg_write low must not flag or write.
    do_reset();
    drive(1'b0, 32'h0000_0060, 32'hAAAA_AAAA, 5'd5, 5'd6);
    @(posedge clk);
    #1;
    check("rw0_multihot_err", {31'h0, bus.onehot_err}, 32'h0);
    check("rw0_multihot_a", bus.a_q, 32'h0);
    bus.wr_onehot = 'x;
    @(posedge clk);
    #1;
    check("rw0_x_err", {31'h0, bus.onehot_err}, 32'h0);
    check("rw0_x_rd2", bus.rd2, 32'h0);
    bus.ra1 = 5'd28;
    #1;
    check("rw0_x_gp", bus.rd1, GP);

    // Reset falling ahead of an edge that would write $sp.
    @(posedge clk);
    #1;
    drive(1'b1, 32'h2000_0000, 32'hCAFE_0000, 5'd29, 5'd29);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstwr_a_q", bus.a_q, 32'h0);
    check("rstwr_b_q", bus.b_q, 32'h0);
    check("rstwr_rd1", bus.rd1, SP);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 5'd29, 5'd29);
    @(posedge clk);
    #1;
    check("rstwr_after_rd1", bus.rd1, SP);
    check("rstwr_after_a_q", bus.a_q, SP);
    model_reset();

    // Randomized traffic; a_q/b_q expected as the register contents after the edge.
    for (int c = 0; c < 600; c++) begin
      rw  = ($urandom_range(0, 3) != 0);
      wd  = $urandom;
      ra1 = 5'($urandom_range(0, 31));
      ra2 = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 5))
        0:       oh = 32'h0;
        1, 2, 3: oh = 32'h1 << $urandom_range(0, 31);
        4:       oh = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
        default: oh = $urandom;
      endcase
      if ($urandom_range(0, 2) == 0) begin
        for (int b = 31; b >= 0; b--) if (oh[b]) ra1 = 5'(b);
      end
      drive(rw, oh, wd, ra1, ra2);
      if (!rw && $urandom_range(0, 7) == 0) bus.wr_onehot = 'x;
      #1;
      check("rnd_rd1", bus.rd1, mem[ra1]);
      check("rnd_rd2", bus.rd2, mem[ra2]);
      if (rw) begin
        n = $countones(oh[31:1]);
        if (n == 1) begin
          idx = 0;
          for (int b = 1; b < 32; b++) if (oh[b]) idx = b;
          mem[idx] = wd;
        end else if (n >= 2) begin
          err_m = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      check("rnd_a_q", bus.a_q, mem[ra1]);
      check("rnd_b_q", bus.b_q, mem[ra2]);
      check("rnd_err", {31'h0, bus.onehot_err}, {31'h0, err_m});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
